// File: rtl/tlp_rx_decoder.sv
// Decodes 64-bit RX TLP beats into 43-bit Action words: register writes, register
// reads and error reports, with one Action in flight and a saturating error counter.
module tlp_rx_decoder #(
    parameter int DROP_C2F = 1
) (
    input  logic        pcieClk_in,
    input  logic        pcieRstN_in,
    input  logic [63:0] rxData_in,
    input  logic        rxValid_in,
    output logic        rxReady_out,
    input  logic [1:0]  rxSOP_in,
    input  logic        rxEOP_in,
    output logic [42:0] actData_out,
    output logic        actValid_out,
    input  logic        actReady_in,
    output logic [15:0] errCount_out
);

    localparam logic [1:0] SOP_NONE  = 2'b00;
    localparam logic [1:0] SOP_REG   = 2'b01;
    localparam logic [1:0] SOP_C2F   = 2'b10;

    localparam logic [1:0] FMT_NODATA   = 2'b00;
    localparam logic [1:0] FMT_WITHDATA = 2'b10;

    localparam logic [1:0] ACT_READ  = 2'b00;
    localparam logic [1:0] ACT_WRITE = 2'b01;
    localparam logic [1:0] ACT_ERROR = 2'b10;

    localparam logic [31:0] ERR_TRUNC = 32'd1;
    localparam logic [31:0] ERR_UNSUP = 32'd2;
    localparam logic [31:0] ERR_LEN   = 32'd3;
    localparam logic [31:0] ERR_NOEOP = 32'd4;
    localparam logic [31:0] ERR_SOP   = 32'd5;
    localparam logic [31:0] ERR_C2F   = 32'd6;

    localparam bit REPORT_C2F = (DROP_C2F == 32'sd0);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE1 = 3'd1,
        ST_READ1  = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_EMIT   = 3'd4
    } state_t;

    function automatic logic [42:0] pack_err(input logic [31:0] code);
        return {ACT_ERROR, 9'd0, code};
    endfunction

    function automatic logic [42:0] pack_write(input logic [8:0] chan, input logic [31:0] data);
        return {ACT_WRITE, chan, data};
    endfunction

    function automatic logic [42:0] pack_read(input logic [8:0] chan, input logic [15:0] req_id,
                                              input logic [7:0] tag);
        return {ACT_READ, chan, req_id, tag, 8'h00};
    endfunction

    state_t      state_r;
    state_t      after_r;
    state_t      nxt_state_s;
    state_t      after_s;
    state_t      end_or_drain_s;
    logic        ready_en_r;
    logic        act_valid_r;
    logic [42:0] act_data_r;
    logic [15:0] err_cnt_r;
    logic [15:0] req_id_r;
    logic [7:0]  tag_r;

    logic        beat_acc_s;
    logic        act_hs_s;
    logic        emit_s;
    logic        cap_s;
    logic [42:0] emit_data_s;
    logic [1:0]  fmt_s;
    logic [4:0]  typ_s;
    logic [9:0]  dw_count_s;
    logic [8:0]  chan_s;
    logic        unsup_s;
    logic        unused_s;

    assign fmt_s      = rxData_in[30:29];
    assign typ_s      = rxData_in[28:24];
    assign dw_count_s = rxData_in[9:0];
    assign chan_s     = rxData_in[11:3];
    assign unsup_s    = (typ_s != 5'd0) || ((fmt_s != FMT_NODATA) && (fmt_s != FMT_WITHDATA));
    assign unused_s   = ^{rxData_in[31], rxData_in[23:12], rxData_in[2:0]};

    assign rxReady_out    = ready_en_r & (state_r != ST_EMIT);
    assign beat_acc_s     = rxValid_in & rxReady_out;
    assign act_hs_s       = (state_r == ST_EMIT) & act_valid_r & actReady_in;
    assign end_or_drain_s = rxEOP_in ? ST_IDLE : ST_DRAIN;

    assign actData_out  = act_data_r;
    assign actValid_out = act_valid_r;
    assign errCount_out = err_cnt_r;

    // Beat classification: next state, the Action to queue and where to go after EMIT.
    always_comb begin
        nxt_state_s = state_r;
        after_s     = ST_IDLE;
        emit_s      = 1'b0;
        emit_data_s = 43'd0;
        cap_s       = 1'b0;
        if (beat_acc_s) begin
            case (state_r)
                ST_IDLE: begin
                    case (rxSOP_in)
                        SOP_NONE: begin
                            nxt_state_s = ST_IDLE;
                        end
                        SOP_REG: begin
                            if (rxEOP_in) begin
                                emit_s      = 1'b1;
                                emit_data_s = pack_err(ERR_TRUNC);
                                after_s     = ST_IDLE;
                                nxt_state_s = ST_EMIT;
                            end else if (unsup_s) begin
                                emit_s      = 1'b1;
                                emit_data_s = pack_err(ERR_UNSUP);
                                after_s     = ST_DRAIN;
                                nxt_state_s = ST_EMIT;
                            end else if (dw_count_s != 10'd1) begin
                                emit_s      = 1'b1;
                                emit_data_s = pack_err(ERR_LEN);
                                after_s     = ST_DRAIN;
                                nxt_state_s = ST_EMIT;
                            end else if (fmt_s == FMT_WITHDATA) begin
                                nxt_state_s = ST_WRITE1;
                            end else begin
                                cap_s       = 1'b1;
                                nxt_state_s = ST_READ1;
                            end
                        end
                        default: begin
                            // C2F and foreign packets are skipped; C2F may also be reported.
                            if ((rxSOP_in == SOP_C2F) && REPORT_C2F) begin
                                emit_s      = 1'b1;
                                emit_data_s = pack_err(ERR_C2F);
                                after_s     = end_or_drain_s;
                                nxt_state_s = ST_EMIT;
                            end else begin
                                nxt_state_s = end_or_drain_s;
                            end
                        end
                    endcase
                end
                ST_WRITE1, ST_READ1: begin
                    emit_s      = 1'b1;
                    nxt_state_s = ST_EMIT;
                    if (rxSOP_in != SOP_NONE) begin
                        emit_data_s = pack_err(ERR_SOP);
                        after_s     = end_or_drain_s;
                    end else if (!rxEOP_in) begin
                        emit_data_s = pack_err(ERR_NOEOP);
                        after_s     = ST_DRAIN;
                    end else if (state_r == ST_WRITE1) begin
                        emit_data_s = pack_write(chan_s, rxData_in[63:32]);
                        after_s     = ST_IDLE;
                    end else begin
                        emit_data_s = pack_read(chan_s, req_id_r, tag_r);
                        after_s     = ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    nxt_state_s = end_or_drain_s;
                end
                default: begin
                    nxt_state_s = ST_IDLE;
                end
            endcase
        end else if (act_hs_s) begin
            nxt_state_s = after_r;
        end else begin
            nxt_state_s = state_r;
        end
    end

    // State, Action output register, read-header capture and error counter.
    always_ff @(posedge pcieClk_in or negedge pcieRstN_in) begin
        if (!pcieRstN_in) begin
            state_r     <= ST_IDLE;
            after_r     <= ST_IDLE;
            ready_en_r  <= 1'b0;
            act_valid_r <= 1'b0;
            act_data_r  <= 43'd0;
            err_cnt_r   <= 16'd0;
            req_id_r    <= 16'd0;
            tag_r       <= 8'd0;
        end else begin
            ready_en_r <= 1'b1;
            state_r    <= nxt_state_s;
            if (emit_s) begin
                act_valid_r <= 1'b1;
                act_data_r  <= emit_data_s;
                after_r     <= after_s;
            end else if (act_hs_s) begin
                act_valid_r <= 1'b0;
                if ((act_data_r[42:41] == ACT_ERROR) && (err_cnt_r != 16'hFFFF)) begin
                    err_cnt_r <= err_cnt_r + 16'd1;
                end else begin
                    err_cnt_r <= err_cnt_r;
                end
            end else begin
                act_valid_r <= act_valid_r;
            end
            if (cap_s) begin
                req_id_r <= rxData_in[63:48];
                tag_r    <= rxData_in[47:40];
            end else begin
                req_id_r <= req_id_r;
                tag_r    <= tag_r;
            end
        end
    end

endmodule

// File: tb/tb_tlp_rx_decoder.sv
// Bench for tlp_rx_decoder: two instances (C2F dropped / reported) driven by a directed
// table, a backpressure and reset sequence, and random traffic against a packet-rule model.
module tb_tlp_rx_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] rx_data = 64'd0;
    logic [1:0]  rx_sop = 2'd0;
    logic        rx_eop = 1'b0;
    logic        rx_valid [2];
    logic        act_ready [2];
    logic        rx_ready [2];
    logic [42:0] act_data [2];
    logic        act_valid [2];
    logic [15:0] err_cnt [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tlp_rx_decoder #(.DROP_C2F(1)) dut0 (
        .pcieClk_in(clk), .pcieRstN_in(rst_n), .rxData_in(rx_data), .rxValid_in(rx_valid[0]),
        .rxReady_out(rx_ready[0]), .rxSOP_in(rx_sop), .rxEOP_in(rx_eop),
        .actData_out(act_data[0]), .actValid_out(act_valid[0]), .actReady_in(act_ready[0]),
        .errCount_out(err_cnt[0])
    );

    tlp_rx_decoder #(.DROP_C2F(0)) dut1 (
        .pcieClk_in(clk), .pcieRstN_in(rst_n), .rxData_in(rx_data), .rxValid_in(rx_valid[1]),
        .rxReady_out(rx_ready[1]), .rxSOP_in(rx_sop), .rxEOP_in(rx_eop),
        .actData_out(act_data[1]), .actValid_out(act_valid[1]), .actReady_in(act_ready[1]),
        .errCount_out(err_cnt[1])
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic logic [42:0] e_act(input int code);
        return {2'b10, 9'd0, 32'(code)};
    endfunction

    // ---------------- reference model: packet rules, one per instance ----------------
    int          m_mode [2];   // 0 between packets, 1 want write data, 2 want read QW1, 3 skipping
    logic [15:0] m_req [2];
    logic [7:0]  m_tag [2];
    int          m_cnt [2];

    function automatic void model_reset(input int k);
        m_mode[k] = 0;
        m_req[k]  = 16'd0;
        m_tag[k]  = 8'd0;
        m_cnt[k]  = 0;
    endfunction

    function automatic void model_beat(input int k, input logic [63:0] d, input logic [1:0] sop,
                                       input logic eop, output bit has, output logic [42:0] act);
        logic [1:0] fmt;
        fmt = d[30:29];
        has = 1'b0;
        act = 43'd0;
        if (m_mode[k] == 0) begin
            if (sop == 2'd1) begin
                if (eop) begin
                    has = 1'b1; act = e_act(1);
                end else if (d[28:24] != 5'd0 || !(fmt == 2'b00 || fmt == 2'b10)) begin
                    has = 1'b1; act = e_act(2); m_mode[k] = 3;
                end else if (d[9:0] != 10'd1) begin
                    has = 1'b1; act = e_act(3); m_mode[k] = 3;
                end else if (fmt == 2'b10) begin
                    m_mode[k] = 1;
                end else begin
                    m_mode[k] = 2; m_req[k] = d[63:48]; m_tag[k] = d[47:40];
                end
            end else if (sop != 2'd0) begin
                if (sop == 2'd2 && k == 1) begin
                    has = 1'b1; act = e_act(6);
                end
                m_mode[k] = eop ? 0 : 3;
            end
        end else if (m_mode[k] == 3) begin
            if (eop) m_mode[k] = 0;
        end else begin
            has = 1'b1;
            if (sop != 2'd0) begin
                act = e_act(5); m_mode[k] = eop ? 0 : 3;
            end else if (!eop) begin
                act = e_act(4); m_mode[k] = 3;
            end else if (m_mode[k] == 1) begin
                act = {2'b01, d[11:3], d[63:32]}; m_mode[k] = 0;
            end else begin
                act = {2'b00, d[11:3], m_req[k], m_tag[k], 8'h00}; m_mode[k] = 0;
            end
        end
    endfunction

    // ---------------- cycle monitor: compares both instances every edge ----------------
    bit          p_en [2];
    bit          p_acc [2];
    bit          p_hs [2];
    bit          p_v [2];
    logic [42:0] p_d [2];
    logic [63:0] b_d;
    logic [1:0]  b_sop;
    logic        b_eop;
    bit          m_has;
    logic [42:0] m_act;

    initial begin : monitor
        forever begin
            @(negedge clk);
            #4;
            b_d = rx_data; b_sop = rx_sop; b_eop = rx_eop;
            for (int k = 0; k < 2; k++) begin
                p_en[k]  = rst_n;
                p_acc[k] = rx_valid[k] && rx_ready[k];
                p_hs[k]  = act_valid[k] && act_ready[k];
                p_v[k]   = act_valid[k];
                p_d[k]   = act_data[k];
            end
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                if (!rst_n) begin
                    model_reset(k);
                end else if (p_en[k]) begin
                    if (p_hs[k]) begin
                        if (p_d[k][42:41] == 2'b10 && m_cnt[k] < 65535) m_cnt[k]++;
                        chk("mon_hs_clear", 64'(act_valid[k]), 64'd0);
                    end else if (p_v[k]) begin
                        chk("mon_hold_valid", 64'(act_valid[k]), 64'd1);
                        chk("mon_hold_data", 64'(act_data[k]), 64'(p_d[k]));
                    end else begin
                        m_has = 1'b0; m_act = 43'd0;
                        if (p_acc[k]) model_beat(k, b_d, b_sop, b_eop, m_has, m_act);
                        chk("mon_valid", 64'(act_valid[k]), 64'(m_has));
                        if (m_has) chk("mon_action", 64'(act_data[k]), 64'(m_act));
                    end
                    chk("mon_ready", 64'(rx_ready[k]), 64'(!act_valid[k]));
                    chk("mon_errcnt", 64'(err_cnt[k]), 64'(m_cnt[k]));
                end
            end
        end
    end

    // ---------------- directed table ----------------
    typedef struct {
        logic [63:0] d;
        logic [1:0]  sop;
        logic        eop;
        bit          h0;
        logic [42:0] a0;
        bit          h1;
        logic [42:0] a1;
        int          c0;
        int          c1;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [63:0] d, input logic [1:0] sop, input logic eop,
                       input bit h0, input logic [42:0] a0, input bit h1, input logic [42:0] a1,
                       input int c0, input int c1);
        vec_t v;
        v.d = d; v.sop = sop; v.eop = eop; v.h0 = h0; v.a0 = a0; v.h1 = h1; v.a1 = a1;
        v.c0 = c0; v.c1 = c1;
        tbl.push_back(v);
    endtask

    task automatic drive_beat(input logic [63:0] d, input logic [1:0] sop, input logic eop);
        int n;
        n = 0;
        @(negedge clk);
        while (!(rx_ready[0] && rx_ready[1]) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("ready_timeout", 64'd0, 64'd1);
        rx_data = d; rx_sop = sop; rx_eop = eop;
        rx_valid[0] = 1'b1; rx_valid[1] = 1'b1;
        @(negedge clk);
        rx_valid[0] = 1'b0; rx_valid[1] = 1'b0;
    endtask

    task automatic pulse_ready();
        act_ready[0] = 1'b1; act_ready[1] = 1'b1;
        @(negedge clk);
        act_ready[0] = 1'b0; act_ready[1] = 1'b0;
    endtask

    task automatic gen_beat(output logic [63:0] d, output logic [1:0] sop, output logic eop);
        int r;
        d = {$urandom, $urandom};
        r = $urandom_range(0, 9);
        sop = (r < 5) ? 2'd0 : (r < 8) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
        if ($urandom_range(0, 9) < 8) d[30:29] = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00;
        if ($urandom_range(0, 9) < 9) d[28:24] = 5'd0;
        if ($urandom_range(0, 9) < 8) d[9:0] = 10'd1;
        eop = ($urandom_range(0, 3) == 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    logic [42:0] w1;
    logic [42:0] r1;
    logic [63:0] gd;
    logic [1:0]  gs;
    logic        ge;

    initial begin : stim
        rx_valid[0] = 1'b0; rx_valid[1] = 1'b0;
        act_ready[0] = 1'b0; act_ready[1] = 1'b0;
        w1 = {2'b01, 9'h005, 32'hDEADBEEF};
        r1 = {2'b00, 9'h101, 16'h0100, 8'h2A, 8'h00};

        add(64'h0000000F_40000001, 2'd1, 1'b0, 0, 43'd0, 0, 43'd0, 0, 0);
        add(64'hDEADBEEF_0000002C, 2'd0, 1'b1, 1, w1, 1, w1, 0, 0);
        add(64'h01002A0F_00000001, 2'd1, 1'b0, 0, 43'd0, 0, 43'd0, 0, 0);
        add(64'h00000000_0000080C, 2'd0, 1'b1, 1, r1, 1, r1, 0, 0);
        add(64'h0000000F_40000004, 2'd1, 1'b0, 1, e_act(3), 1, e_act(3), 1, 1);
        add(64'h12345678_9ABCDEF0, 2'd0, 1'b0, 0, 43'd0, 0, 43'd0, 1, 1);
        add(64'h0000000F_40000001, 2'd1, 1'b0, 0, 43'd0, 0, 43'd0, 1, 1);
        add(64'h00000000_00000000, 2'd0, 1'b1, 0, 43'd0, 0, 43'd0, 1, 1);
        add(64'h0000000F_40000001, 2'd1, 1'b1, 1, e_act(1), 1, e_act(1), 2, 2);
        add(64'h0000000F_40000001, 2'd3, 1'b0, 0, 43'd0, 0, 43'd0, 2, 2);
        add(64'h00000000_00000000, 2'd0, 1'b0, 0, 43'd0, 0, 43'd0, 2, 2);
        add(64'h00000000_00000000, 2'd0, 1'b1, 0, 43'd0, 0, 43'd0, 2, 2);
        add(64'h00000000_00000000, 2'd2, 1'b1, 0, 43'd0, 1, e_act(6), 2, 3);
        add(64'h00000000_00000000, 2'd2, 1'b0, 0, 43'd0, 1, e_act(6), 2, 4);
        add(64'h00000000_00000000, 2'd0, 1'b1, 0, 43'd0, 0, 43'd0, 2, 4);
        add(64'h0000000F_41000001, 2'd1, 1'b0, 1, e_act(2), 1, e_act(2), 3, 5);
        add(64'h00000000_00000000, 2'd0, 1'b1, 0, 43'd0, 0, 43'd0, 3, 5);
        add(64'h0000000F_40000001, 2'd1, 1'b0, 0, 43'd0, 0, 43'd0, 3, 5);
        add(64'h00000000_00000000, 2'd0, 1'b0, 1, e_act(4), 1, e_act(4), 4, 6);
        add(64'h00000000_00000000, 2'd0, 1'b1, 0, 43'd0, 0, 43'd0, 4, 6);
        add(64'h01002A0F_00000001, 2'd1, 1'b0, 0, 43'd0, 0, 43'd0, 4, 6);
        add(64'h00000000_00000000, 2'd3, 1'b1, 1, e_act(5), 1, e_act(5), 5, 7);
        add(64'h0000000F_20000001, 2'd1, 1'b0, 1, e_act(2), 1, e_act(2), 6, 8);
        add(64'h00000000_00000000, 2'd0, 1'b1, 0, 43'd0, 0, 43'd0, 6, 8);

        #2;
        for (int k = 0; k < 2; k++) begin
            chk("reset_ready", 64'(rx_ready[k]), 64'd0);
            chk("reset_valid", 64'(act_valid[k]), 64'd0);
            chk("reset_data", 64'(act_data[k]), 64'd0);
            chk("reset_errcnt", 64'(err_cnt[k]), 64'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive_beat(tbl[i].d, tbl[i].sop, tbl[i].eop);
            chk($sformatf("tbl%0d_valid0", i), 64'(act_valid[0]), 64'(tbl[i].h0));
            chk($sformatf("tbl%0d_valid1", i), 64'(act_valid[1]), 64'(tbl[i].h1));
            if (tbl[i].h0) chk($sformatf("tbl%0d_data0", i), 64'(act_data[0]), 64'(tbl[i].a0));
            if (tbl[i].h1) chk($sformatf("tbl%0d_data1", i), 64'(act_data[1]), 64'(tbl[i].a1));
            pulse_ready();
            chk($sformatf("tbl%0d_cnt0", i), 64'(err_cnt[0]), 64'(tbl[i].c0));
            chk($sformatf("tbl%0d_cnt1", i), 64'(err_cnt[1]), 64'(tbl[i].c1));
        end

        // Backpressure on a register write Action.
        drive_beat(64'h0000000F_40000001, 2'd1, 1'b0);
        drive_beat(64'hDEADBEEF_0000002C, 2'd0, 1'b1);
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", 64'(act_valid[0]), 64'd1);
            chk("bp_data", 64'(act_data[0]), 64'(w1));
            chk("bp_ready_low", 64'(rx_ready[0]), 64'd0);
            @(negedge clk);
        end
        pulse_ready();
        chk("bp_valid_clear", 64'(act_valid[0]), 64'd0);
        chk("bp_ready_back", 64'(rx_ready[0]), 64'd1);

        // Random traffic, independent valid/ready per instance.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            gen_beat(gd, gs, ge);
            rx_data = gd; rx_sop = gs; rx_eop = ge;
            for (int k = 0; k < 2; k++) begin
                rx_valid[k]  = ($urandom_range(0, 3) != 0);
                act_ready[k] = ($urandom_range(0, 2) != 0);
            end
        end
        @(negedge clk);
        rx_valid[0] = 1'b0; rx_valid[1] = 1'b0;
        act_ready[0] = 1'b1; act_ready[1] = 1'b1;
        repeat (3) @(negedge clk);
        drive_beat(64'd0, 2'd0, 1'b1);
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) chk("rand_errcnt", 64'(err_cnt[k]), 64'(m_cnt[k]));
        act_ready[0] = 1'b0; act_ready[1] = 1'b0;

        // Reset between QW0 and QW1 of a write.
        drive_beat(64'h0000000F_40000001, 2'd1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_ready", 64'(rx_ready[k]), 64'd0);
            chk("rst_valid", 64'(act_valid[k]), 64'd0);
            chk("rst_data", 64'(act_data[k]), 64'd0);
            chk("rst_errcnt", 64'(err_cnt[k]), 64'd0);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        drive_beat(64'hDEADBEEF_0000002C, 2'd0, 1'b1);
        chk("rst_orphan_qw1", 64'(act_valid[0]), 64'd0);
        drive_beat(64'h01002A0F_00000001, 2'd1, 1'b0);
        drive_beat(64'h00000000_0000080C, 2'd0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            chk("rst_read_valid", 64'(act_valid[k]), 64'd1);
            chk("rst_read_data", 64'(act_data[k]), 64'(r1));
        end
        pulse_ready();
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tlp_rx_decoder.md
TLP_RX_DECODER -- requirements
Module: tlp_rx_decoder

Interface
REQ-001 SHALL have parameter DROP_C2F, default 1: 1 = discard SOP_C2F packets silently; 0 = discard them and emit error code 6.
REQ-002 SHALL have port pcieClk_in, input, 1 bit: the single clock for the block.
REQ-003 SHALL have port pcieRstN_in, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port rxData_in, input, 64 bits: one QW of the RX TLP.
REQ-005 SHALL have port rxValid_in, input, 1 bit: rxData_in is valid.
REQ-006 SHALL have port rxReady_out, output, 1 bit: the decoder accepts the current beat.
REQ-007 SHALL have port rxSOP_in, input, 2 bits: SopBar code (NONE 00, REG 01, C2F 10, OTHER 11).
REQ-008 SHALL have port rxEOP_in, input, 1 bit: the current beat is the last beat of the TLP.
REQ-009 SHALL have port actData_out, output, 43 bits: Action word to the RX->TX pipe.
REQ-010 SHALL have port actValid_out, output, 1 bit: actData_out is valid.
REQ-011 SHALL have port actReady_in, input, 1 bit: the downstream stage accepts the Action.
REQ-012 SHALL have port errCount_out, output, 16 bits: saturating count of emitted ACT_ERROR actions.

Function
REQ-013 A beat SHALL be accepted only when rxValid_in and rxReady_out are both 1 on a rising edge.
REQ-014 QW0 fields SHALL be decoded as:
- fmt = rxData_in[30:29]
- typ = rxData_in[28:24]
- dwCount = rxData_in[9:0]
- reqID = rxData_in[63:48]
- tag = rxData_in[47:40]
REQ-015 The FSM SHALL have exactly five states: IDLE, WRITE1, READ1, DRAIN and EMIT.
REQ-016 rxReady_out SHALL equal readyEn AND (state != EMIT), where readyEn is a flop that resets to 0 and sets to 1 on the first clock edge after reset release.
REQ-017 In IDLE, accepted beats with SOP_NONE SHALL be ignored.
REQ-018 In IDLE, an accepted SOP_OTHER beat SHALL go to DRAIN, or stay in IDLE if EOP is set; no Action is emitted.
REQ-019 In IDLE, an accepted SOP_C2F beat SHALL behave as SOP_OTHER, and SHALL additionally queue error 6 when DROP_C2F = 0.
REQ-020 In IDLE, an accepted SOP_REG beat SHALL be classified in priority order:
- EOP set: error 1 (truncated), go to IDLE.
- typ != 0, or fmt not in {H3DW_NODATA, H3DW_WITHDATA}: error 2 (unsupported), go to DRAIN.
- dwCount != 1: error 3, go to DRAIN.
- fmt = H3DW_WITHDATA: go to WRITE1.
- fmt = H3DW_NODATA: capture reqID and tag, go to READ1.
REQ-021 In WRITE1 or READ1, an accepted beat with SOP != NONE SHALL queue error 5 and go to DRAIN, or to IDLE if EOP is set.
REQ-022 In WRITE1 or READ1, an accepted beat without EOP SHALL queue error 4 and go to DRAIN.
REQ-023 In WRITE1, an accepted beat with EOP SHALL build a RegWrite: typ = ACT_WRITE, chan = rxData_in[11:3], data = rxData_in[63:32].
REQ-024 In READ1, an accepted beat with EOP SHALL build a RegRead: typ = ACT_READ, chan = rxData_in[11:3], the captured reqID and tag, reserved = 0.
REQ-025 Action packing SHALL be:
- typ in [42:41]
- chan in [40:32]
- RegWrite data, or ErrorCode code, in [31:0]
- RegRead reqID in [31:16], tag in [15:8], zeros in [7:0]
- ErrorCode chan = 0
REQ-026 Every queued Action SHALL be registered into actData_out with actValid_out = 1 on the same edge that accepted the beat, and the FSM SHALL enter EMIT; latency is one cycle.
REQ-027 On leaving EMIT, the FSM SHALL go to DRAIN if the queued error's packet has not yet seen EOP, otherwise to IDLE.
REQ-028 In EMIT, actData_out and actValid_out SHALL hold stable until actValid_out AND actReady_in; actValid_out SHALL clear on that edge, and the FSM SHALL take its recorded next state.
REQ-029 In DRAIN, accepted beats SHALL be discarded until one with EOP, then the FSM SHALL go to IDLE; SOP beats inside DRAIN SHALL be discarded without error.
REQ-030 errCount_out SHALL increment by 1 on each ACT_ERROR handshake and SHALL saturate at 0xFFFF.

Reset
REQ-031 While pcieRstN_in = 0, asynchronously:
- state = IDLE
- readyEn = 0, so rxReady_out = 0
- actValid_out = 0
- actData_out = 0
- errCount_out = 0
- captured reqID and tag = 0
REQ-032 A reset asserted mid-packet or in EMIT SHALL discard the pending Action; the decoder SHALL resume in IDLE and treat the next SOP beat as a fresh TLP.

Verification
REQ-033 Register write: QW0 0x0000000F_40000001 (SOP_REG), then QW1 0xDEADBEEF_0000002C (EOP) -> one cycle later actData_out = {01, 0x005, 0xDEADBEEF}, actValid_out = 1.
REQ-034 Register read: QW0 0x01002A0F_00000001 (SOP_REG), then QW1 0x00000000_0000080C (EOP) -> actData_out = {00, 0x101, 0x0100, 0x2A, 0x00}.
REQ-035 Backpressure: hold actReady_in = 0 for 5 cycles after the REQ-033 Action -> actData_out stable, rxReady_out = 0 throughout; actReady_in = 1 -> handshake, then rxReady_out = 1 on the next cycle.
REQ-036 Errors: QW0 with dwCount = 4 and no EOP, then 3 beats ending in EOP -> exactly one Action {10, 0, 3}, errCount_out = 1; single-beat SOP_REG with EOP -> code 1, errCount_out = 2.
REQ-037 Foreign traffic: SOP_OTHER 3-beat packet -> no Action; SOP_C2F with DROP_C2F = 0 -> code 6; SOP_C2F with DROP_C2F = 1 -> no Action.
REQ-038 Reset: assert pcieRstN_in between QW0 and QW1 of a write -> all outputs 0; after release, a fresh REQ-034 read decodes correctly.
